led_shift_controller: RTL



---
 rtl/led_shift_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_shift_controller.sv
// led_shift_controller: command-driven sequencer for the 8-bit LED rotator.
// Owns the LED register, the prescale/period step timer and the shift-mode
// state, and accepts LOAD/SET_PERIOD/SET_MODE/START/STOP/STEP commands over
// a valid/ready port.
module led_shift_controller #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned PRESCALE      = 250_000,
    parameter logic [7:0]  RESET_PATTERN = 8'b0001_1111,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] leds,
    output logic       running,
    output logic       step_pulse
);

    // A zero prescale or a zero clock frequency is a configuration error.
    if (PRESCALE < 1 || CLK_FREQ == 0) begin : g_bad_params
        $error("led_shift_controller: PRESCALE must be >= 1 and CLK_FREQ nonzero");
    end

    localparam int unsigned     PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESCALE_LAST = PW'(PRESCALE - 1);

    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_SET_PERIOD = 3'd2;
    localparam logic [2:0] OP_SET_MODE   = 3'd3;
    localparam logic [2:0] OP_START      = 3'd4;
    localparam logic [2:0] OP_STOP       = 3'd5;
    localparam logic [2:0] OP_STEP       = 3'd6;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    localparam state_t RESET_STATE = AUTO_START ? ST_RUNNING : ST_STOPPED;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescale_cnt;
    logic [7:0]    period_cnt;
    logic [7:0]    period;
    logic [1:0]    mode;
    logic          dir;
    logic [2:0]    bounce_cnt;

    logic          handshake;
    logic          restart_cmd;
    logic          tick;
    logic          period_last;
    logic          shift_fire;
    logic [7:0]    leds_shifted;
    logic          dir_shifted;
    logic [2:0]    bounce_shifted;

    // Handshake decode and next-state selection for the run/stop/step FSM.
    always_comb begin
        state_next  = state;
        cmd_ready   = (state != ST_STEP);
        running     = (state == ST_RUNNING);
        handshake   = cmd_valid && (state != ST_STEP);
        restart_cmd = handshake && (cmd_op == OP_LOAD || cmd_op == OP_SET_PERIOD ||
                                    cmd_op == OP_SET_MODE || cmd_op == OP_START ||
                                    cmd_op == OP_STOP);
        case (state)
            ST_STOPPED: begin
                if (handshake && cmd_op == OP_START) begin
                    state_next = ST_RUNNING;
                end else if (handshake && cmd_op == OP_STEP) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUNNING: begin
                if (handshake && cmd_op == OP_STOP) begin
                    state_next = ST_STOPPED;
                end
            end
            ST_STEP: begin
                state_next = ST_STOPPED;
            end
            default: begin
                state_next = ST_STOPPED;
            end
        endcase
    end

    // Shift timing and the shifted LED value; a restarting command suppresses a due shift.
    always_comb begin
        tick           = (state == ST_RUNNING) && (prescale_cnt == PRESCALE_LAST);
        period_last    = (period_cnt == (period - 8'd1));
        shift_fire     = (tick && period_last && !restart_cmd) || (state == ST_STEP);
        leds_shifted   = leds;
        dir_shifted    = dir;
        bounce_shifted = bounce_cnt;
        case (mode)
            MODE_ROTL: leds_shifted = {leds[6:0], leds[7]};
            MODE_ROTR: leds_shifted = {leds[0], leds[7:1]};
            MODE_BOUNCE: begin
                leds_shifted = dir ? {leds[0], leds[7:1]} : {leds[6:0], leds[7]};
                if (bounce_cnt == 3'd6) begin
                    bounce_shifted = 3'd0;
                    dir_shifted    = ~dir;
                end else begin
                    bounce_shifted = bounce_cnt + 3'd1;
                end
            end
            default: leds_shifted = leds;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Prescale and period counters; held at zero outside RUNNING and on any restart.
    always_ff @(posedge clk) begin
        if (!rst_n || restart_cmd || state != ST_RUNNING) begin
            prescale_cnt <= '0;
            period_cnt   <= 8'd0;
        end else if (tick) begin
            prescale_cnt <= '0;
            period_cnt   <= period_last ? 8'd0 : period_cnt + 8'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

    // LED register, mode/period configuration, bounce tracking and the step pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds       <= RESET_PATTERN;
            mode       <= MODE_ROTL;
            period     <= 8'd1;
            dir        <= 1'b0;
            bounce_cnt <= 3'd0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= shift_fire;
            if (shift_fire) begin
                leds       <= leds_shifted;
                dir        <= dir_shifted;
                bounce_cnt <= bounce_shifted;
            end
            if (handshake) begin
                case (cmd_op)
                    OP_LOAD: begin
                        leds       <= cmd_data;
                        bounce_cnt <= 3'd0;
                        dir        <= 1'b0;
                    end
                    OP_SET_PERIOD: begin
                        period <= (cmd_data == 8'd0) ? 8'd1 : cmd_data;
                    end
                    OP_SET_MODE: begin
                        mode       <= cmd_data[1:0];
                        bounce_cnt <= 3'd0;
                        dir        <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
